// File: rtl/bsg_link_bringup_pkg.sv
// Shared types and constants for the bsg_link bring-up sequencer.
package bsg_link_bringup_pkg;

  localparam int unsigned bsg_link_bringup_phase_cycles_default = 5000;

  typedef enum logic [2:0] {
    S_WAIT     = 3'd0,
    S_IO_RESET = 3'd1,
    S_IO_RUN   = 3'd2,
    S_LINK_EN  = 3'd3,
    S_CHIP_RUN = 3'd4,
    S_DONE     = 3'd5
  } bsg_link_bringup_state_e;

  typedef struct packed {
    logic link_reset;
    logic chip_reset;
    logic link_enable;
    logic node_en;
    logic done;
  } bsg_link_bringup_outputs_s;

  localparam bsg_link_bringup_outputs_s bsg_link_bringup_outputs_reset = '{
    link_reset:  1'b0,
    chip_reset:  1'b1,
    link_enable: 1'b0,
    node_en:     1'b0,
    done:        1'b0
  };

  // Counter width that stays at least one bit wide when the count range is 1.
  function automatic int unsigned safe_clog2(input int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_link_bringup_phase_timer.sv
// Phase counter: counts enabled cycles up to terminal_p, then wraps to 0 on the advance edge.
module bsg_link_bringup_phase_timer #(
  parameter int unsigned terminal_p = 5000,
  parameter int unsigned width_p    = 13
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  logic [width_p-1:0] count_q;

  assign tc_o = (count_q == width_p'(terminal_p));

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= tc_o ? '0 : count_q + width_p'(1);
    end
  end

endmodule

// File: rtl/bsg_link_bringup_sequencer.sv
// Timed bring-up of one bsg_link_ddr edge and the logic behind it.
// Optional retrain on sustained link error: define BSG_LINK_BRINGUP_RETRAIN_EN.
module bsg_link_bringup_sequencer
  import bsg_link_bringup_pkg::*;
#(
  parameter int unsigned phase_cycles_p = bsg_link_bringup_phase_cycles_default,
  parameter int unsigned retrain_hold_p = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic       restart_i,
  input  logic       link_error_i,
  output logic       link_reset_o,
  output logic       chip_reset_o,
  output logic       link_enable_o,
  output logic       node_en_o,
  output logic       done_o,
  output logic [2:0] state_o
);

  localparam int unsigned lg_phase_cycles_lp = safe_clog2(phase_cycles_p + 1);

  bsg_link_bringup_state_e   state_q, state_n;
  bsg_link_bringup_outputs_s outs_q, outs_n;
  logic timer_clear, timer_en, timer_tc;
  logic restart_req;

  bsg_link_bringup_phase_timer #(
    .terminal_p (phase_cycles_p),
    .width_p    (lg_phase_cycles_lp)
  ) phase_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (timer_clear),
    .en_i    (timer_en),
    .tc_o    (timer_tc)
  );

`ifdef BSG_LINK_BRINGUP_RETRAIN_EN
  localparam int unsigned lg_retrain_lp = safe_clog2(retrain_hold_p + 1);

  logic [lg_retrain_lp-1:0] err_cnt_q;
  logic retrain_req;

  assign retrain_req = (state_q == S_DONE) && (err_cnt_q == lg_retrain_lp'(retrain_hold_p));

  // Consecutive-error run length, only meaningful while parked in S_DONE.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_cnt_q <= '0;
    end else if (restart_i || retrain_req || (state_q != S_DONE) || !link_error_i) begin
      err_cnt_q <= '0;
    end else if (err_cnt_q != lg_retrain_lp'(retrain_hold_p)) begin
      err_cnt_q <= err_cnt_q + lg_retrain_lp'(1);
    end
  end

  assign restart_req = restart_i | retrain_req;
`else
  localparam int unsigned unused_retrain_hold = retrain_hold_p;
  logic unused_link_error;
  assign unused_link_error = link_error_i;
  assign restart_req       = restart_i;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    state_n     = state_q;
    outs_n      = outs_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    if (restart_req) begin
      state_n     = S_WAIT;
      outs_n      = bsg_link_bringup_outputs_reset;
      timer_clear = 1'b1;
    end else begin
      case (state_q)
        S_WAIT: begin
          timer_en = en_i;
          if (en_i && timer_tc) begin
            state_n           = S_IO_RESET;
            outs_n.link_reset = 1'b1;
          end
        end
        S_IO_RESET: begin
          timer_en = en_i;
          if (en_i && timer_tc) begin
            state_n           = S_IO_RUN;
            outs_n.link_reset = 1'b0;
          end
        end
        S_IO_RUN: begin
          timer_en = en_i;
          if (en_i && timer_tc) begin
            state_n            = S_LINK_EN;
            outs_n.link_enable = 1'b1;
          end
        end
        S_LINK_EN: begin
          timer_en = en_i;
          if (en_i && timer_tc) begin
            state_n           = S_CHIP_RUN;
            outs_n.chip_reset = 1'b0;
          end
        end
        S_CHIP_RUN: begin
          timer_en = en_i;
          if (en_i && timer_tc) begin
            state_n        = S_DONE;
            outs_n.node_en = 1'b1;
            outs_n.done    = 1'b1;
          end
        end
        S_DONE: begin
          // Terminal: timer stays parked at 0, outputs hold.
        end
        default: begin
          state_n     = S_WAIT;
          outs_n      = bsg_link_bringup_outputs_reset;
          timer_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_WAIT;
      outs_q  <= bsg_link_bringup_outputs_reset;
    end else begin
      state_q <= state_n;
      outs_q  <= outs_n;
    end
  end

  assign link_reset_o  = outs_q.link_reset;
  assign chip_reset_o  = outs_q.chip_reset;
  assign link_enable_o = outs_q.link_enable;
  assign node_en_o     = outs_q.node_en;
  assign done_o        = outs_q.done;
  assign state_o       = state_q;

endmodule

// File: doc/bsg_link_bringup_sequencer.md
Name: bsg_link_bringup_sequencer

Overview:
Sequences bring-up of one bsg_link_ddr edge and the logic behind it: channel tunnel, wormhole routers and the manycore adapter. It replaces ad-hoc counter FSMs at the top level with one reusable controller. It drives link reset, chip reset, link enable and node enable in a fixed, timed order, then reports done. Restart is supported by a command input and, optionally, by sustained link error.

Parameters:
- phase_cycles_p, 5000, terminal count per phase; each phase lasts phase_cycles_p+1 cycles.
- retrain_hold_p, 16, consecutive link_error_i cycles in DONE that trigger a retrain (used only with macro).
- lg_phase_cycles_lp (localparam), `BSG_SAFE_CLOG2(phase_cycles_p+1), phase counter width.

Ports:
- clk_i  in  1  sequencer clock; same domain as the link core clock.
- reset_i  in  1  asynchronous, active-high reset.
- en_i  in  1  sequencing enable; 0 pauses the counter and holds the state.
- restart_i  in  1  synchronous pulse; restarts the sequence from S_WAIT.
- link_error_i  in  1  link error/loss indication; ignored unless the macro is defined.
- link_reset_o  out  1  bsg_link_ddr reset_i.
- chip_reset_o  out  1  reset for tunnel, routers and adapter.
- link_enable_o  out  1  bsg_link_ddr link_enable_i.
- node_en_o  out  1  adapter en_i.
- done_o  out  1  high in S_DONE.
- state_o  out  3  current state encoding, for debug/chipscope.

Behaviour:
- Reset (async, reset_i=1): state=S_WAIT, count=0, link_reset_o=0, chip_reset_o=1, link_enable_o=0, node_en_o=0, done_o=0, error counter=0.
- States and encodings: S_WAIT=0, S_IO_RESET=1, S_IO_RUN=2, S_LINK_EN=3, S_CHIP_RUN=4, S_DONE=5. Codes 6 and 7 are illegal and go to S_WAIT with reset values.
- In states 0..4, with en_i=1: count increments each cycle.
- When count==phase_cycles_p: count clears to 0 and the state advances. The output action is registered on the same edge:
  - 0->1: link_reset_o=1.
  - 1->2: link_reset_o=0.
  - 2->3: link_enable_o=1.
  - 3->4: chip_reset_o=0.
  - 4->5: node_en_o=1, done_o=1.
- en_i=0: count and state hold; outputs hold.
- S_DONE is terminal. Counter is held at 0; outputs are stable.
- All outputs are registered, with no combinational path from inputs.
- Latency: with en_i held 1, link_reset_o rises on the (phase_cycles_p+1)th rising edge after reset_i falls. node_en_o rises on edge 5*(phase_cycles_p+1).
- restart_i=1 (any state): on the next edge, all registers return to their reset values.
- Priority: reset_i > restart_i > phase advance.
- restart_i coincident with terminal count: restart wins; no advance occurs.
- restart_i while en_i=0: still restarts.
- Counter never wraps. Its width holds phase_cycles_p exactly; count>phase_cycles_p is unreachable.
- phase_cycles_p=0 is legal: one cycle per phase.

Optional Feature:
- Macro: BSG_LINK_BRINGUP_RETRAIN_EN.
- Defined: in S_DONE, a saturating counter counts consecutive cycles with link_error_i=1 and clears on any cycle with link_error_i=0. On reaching retrain_hold_p, the next edge applies the restart action (all reset values, S_WAIT). The counter clears on exit from S_DONE. link_error_i is ignored in states 0..4.
- Undefined: link_error_i is unused, no error counter is instantiated, and S_DONE is left only by reset_i or restart_i.

Decomposition:
- Package bsg_link_bringup_pkg holds:
  - typedef enum logic [2:0] bsg_link_bringup_state_e with the six states above;
  - the default phase count constant 5000.
- Sub-module bsg_link_bringup_phase_timer holds the phase counter (clear, enable, terminal-count output, width from parameter). The FSM stays in the top module.

Test Plan:
- Sequencing: phase_cycles_p=8, en_i=1, release reset -> link_reset_o rises at edge 9 and falls at 18; link_enable_o rises at 27; chip_reset_o falls at 36; node_en_o/done_o rise at 45; state_o steps 0->5.
- Pause: deassert en_i for 20 cycles at edge 12 -> every later transition is delayed by exactly 20 edges (node_en_o at 65); outputs constant during the pause.
- Restart mid-sequence: restart_i pulsed at edge 30 (state 3) -> next edge link_enable_o=0, chip_reset_o=1, state_o=0; sequence completes 45 edges after the pulse.
- Restart vs advance: restart_i asserted on the terminal-count cycle of phase 0 (edge 9) -> link_reset_o stays 0, state_o=0, count=0.
- Async reset: assert reset_i mid-cycle while in S_DONE -> outputs reach reset values without a clock edge.
- Retrain (macro defined, retrain_hold_p=16): in S_DONE, link_error_i high for 15 cycles then low -> no change; high for 16 cycles -> node_en_o=0, chip_reset_o=1, state_o=0 on the following edge. Macro undefined: same stimulus -> no change.
